// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: shared types and UART timing constants for the transmit word scheduler.
package tx_sched_pkg;
    typedef enum logic [1:0] {IDLE, SEND, GAP} sched_state_t;
    localparam int UART_CLKS_PER_BIT  = 434;
    localparam int UART_BITS_PER_BYTE = 10;
    localparam int WORD_GAP_DEFAULT   = 8800;
endpackage

// File: rtl/tx_word_scheduler_rr_pick.sv
// rr_pick: combinational round-robin selector; the search starts just after the last winner.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    input  logic         en_i,
    output logic [N-1:0] grant_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);
    always_comb begin
        idx_o = '0;
        // Scan farthest-first so the nearest valid requester after last_i overwrites the rest.
        for (int k = N; k >= 1; k--) begin
            if (req_i[(int'(last_i) + k) % N]) idx_o = W'((int'(last_i) + k) % N);
        end
        any_o   = en_i & |req_i;
        grant_o = any_o ? N'(1) << idx_o : '0;
    end
endmodule

// File: rtl/tx_word_scheduler.sv
// tx_word_scheduler: round-robin sharing of the 16-bit transceiver transmit path,
// pacing words with a fixed hold-off because the transceiver reports no busy status.
module tx_word_scheduler
    import tx_sched_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = WORD_GAP_DEFAULT,
    parameter int CNT_W      = $clog2(GAP_CYCLES + 1)
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [16*N_REQ-1:0]      req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [15:0]              data_send,
    output logic                     data_send_valid,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic [15:0]              sent_count
);
    localparam int IW = $clog2(N_REQ);

    sched_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]  last_q, last_d, grant_q, grant_d, win;
    logic [15:0]    data_q, data_d, count_q, count_d;
    logic           valid_q, valid_d, any;
    logic [N_REQ-1:0] pick;

    rr_pick #(.N(N_REQ), .W(IW)) u_pick (
        .req_i   (req_valid),
        .last_i  (last_q),
        .en_i    (en),
        .grant_o (pick),
        .idx_o   (win),
        .any_o   (any)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        grant_d = grant_q;
        data_d  = data_q;
        valid_d = 1'b0;
        count_d = count_q;
        case (state_q)
            IDLE: if (any) begin
                data_d  = req_data[16*int'(win) +: 16];
                valid_d = 1'b1;
                grant_d = win;
                last_d  = win;
                count_d = count_q + 16'd1;
                state_d = SEND;
            end
            SEND: begin
                cnt_d   = CNT_W'(GAP_CYCLES);
                state_d = GAP;
            end
            GAP: begin
                if (cnt_q == CNT_W'(1)) state_d = IDLE;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready       = (state_q == IDLE) ? pick : '0;
    assign data_send       = data_q;
    assign data_send_valid = valid_q;
    assign grant_id        = grant_q;
    assign busy            = state_q != IDLE;
    assign sent_count      = count_q;
endmodule

// File: tb/tb_tx_word_scheduler.sv
// tb_tx_word_scheduler: directed and random stimulus against a timeline model of the scheduler.
module tb_tx_word_scheduler;
    localparam int N = 4;
    localparam int G = 8;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          en = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [16*N-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic [15:0]   data_send;
    logic          data_send_valid;
    logic [1:0]    grant_id;
    logic          busy;
    logic [15:0]   sent_count;

    int checks = 0;
    int failures = 0;

    // Model: a word accepted before cycle t makes t the SEND cycle, and the
    // next arbitration is allowed G+1 cycles later.
    int          cyc = 0;
    int          free_at = 0;
    int          pulse_at = -1;
    int          last_m = N - 1;
    logic [15:0] data_m = '0;
    logic [15:0] count_m = '0;
    int          grant_m = 0;

    logic [15:0] pulse_data[$];
    int          pulse_gid[$];
    int          pulse_cyc[$];

    tx_word_scheduler #(.N_REQ(N), .GAP_CYCLES(G)) dut (
        .clk             (clk),
        .rstb            (rstb),
        .en              (en),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .data_send       (data_send),
        .data_send_valid (data_send_valid),
        .grant_id        (grant_id),
        .busy            (busy),
        .sent_count      (sent_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [N-1:0] exp_rdy;
        int w;
        exp_rdy = '0;
        w = -1;
        #1;
        if (cyc >= free_at && en && |req_valid)
            for (int k = 1; k <= N; k++)
                if (w < 0 && req_valid[(last_m + k) % N]) w = (last_m + k) % N;
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        cyc++;
        if (w >= 0) begin
            data_m  = req_data[16*w +: 16];
            grant_m = w;
            last_m  = w;
            count_m = count_m + 16'd1;
            pulse_at = cyc;
            free_at  = cyc + G + 1;
        end
        chk("data_send", 32'(data_send), 32'(data_m));
        chk("data_send_valid", 32'(data_send_valid), 32'(cyc == pulse_at));
        chk("grant_id", 32'(grant_id), 32'(grant_m));
        chk("busy", 32'(busy), 32'(cyc < free_at));
        chk("sent_count", 32'(sent_count), 32'(count_m));
        if (data_send_valid) begin
            pulse_data.push_back(data_send);
            pulse_gid.push_back(int'(grant_id));
            pulse_cyc.push_back(cyc);
        end
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        #1;
        last_m = N - 1; data_m = '0; count_m = '0; grant_m = 0;
        pulse_at = -1; free_at = cyc;
        chk("rst_data", 32'(data_send), 0);
        chk("rst_valid", 32'(data_send_valid), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(sent_count), 0);
        @(posedge clk);
        @(negedge clk);
        rstb = 1'b1;
        pulse_data.delete(); pulse_gid.delete(); pulse_cyc.delete();
    endtask

    task automatic set_words(input logic [15:0] w0, w1, w2, w3);
        req_data = {w3, w2, w1, w0};
    endtask

    initial begin
        logic [15:0] base;
        logic [15:0] rr_exp[5];
        int          wrap_exp[4];
        rr_exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111};
        wrap_exp = '{3, 1, 3, 1};

        do_reset();
        // Single word
        en = 1'b1; req_valid = 4'b0001; set_words(16'hA55A, 0, 0, 0);
        step();
        req_valid = '0;
        chk("single_data", 32'(data_send), 32'h0000A55A);
        chk("single_valid", 32'(data_send_valid), 1);
        repeat (G) begin
            chk("single_busy_hold", 32'(busy), 1);
            step();
        end
        step();
        chk("single_busy_end", 32'(busy), 0);
        chk("single_count", 32'(sent_count), 1);

        // Round robin over all four requesters
        do_reset();
        en = 1'b1; req_valid = 4'b1111;
        set_words(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        repeat (4 * (G + 2) + 1) step();
        chk("rr_pulses", pulse_data.size(), 5);
        for (int i = 0; i < 5 && i < pulse_data.size(); i++) begin
            chk("rr_word", 32'(pulse_data[i]), 32'(rr_exp[i]));
            chk("rr_gid", pulse_gid[i], i % N);
            if (i > 0) chk("rr_spacing", pulse_cyc[i] - pulse_cyc[i-1], G + 2);
        end

        // Pointer wrap and skip
        do_reset();
        req_valid = 4'b1000;
        step();
        req_valid = 4'b1010;
        repeat (3 * (G + 2) + 1) step();
        chk("wrap_pulses", pulse_gid.size(), 4);
        for (int i = 0; i < 4 && i < pulse_gid.size(); i++) chk("wrap_gid", pulse_gid[i], wrap_exp[i]);

        // Enable gating
        repeat (G + 2) step();
        en = 1'b0; req_valid = 4'b1111;
        base = sent_count;
        repeat (50) begin
            chk("gate_ready", 32'(req_ready), 0);
            step();
        end
        chk("gate_count", 32'(sent_count), 32'(base));
        en = 1'b1;
        step();
        repeat (3) step();
        en = 1'b0;
        repeat (30) step();
        chk("gate_drop_count", 32'(sent_count), 32'(base + 16'd1));
        chk("gate_drop_busy", 32'(busy), 0);

        // Hold stability
        en = 1'b1; req_valid = 4'b0001; set_words(16'hBEEF, 0, 0, 0);
        step();
        req_valid = '0;
        repeat (3) step();
        set_words(16'h1234, 16'h5678, 0, 0);
        repeat (G + 4) step();
        chk("hold_data", 32'(data_send), 32'h0000BEEF);

        // Mid-operation reset in GAP cycle 4
        req_valid = 4'b0100; set_words(16'h0F0F, 0, 16'h7777, 0);
        step();
        req_valid = '0;
        repeat (5) step();
        chk("mid_busy", 32'(busy), 1);
        do_reset();
        req_valid = 4'b1111;
        step();
        chk("mid_first_gid", 32'(grant_id), 0);
        chk("mid_first_data", 32'(data_send), 32'h00000F0F);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) req_valid = N'($urandom);
            if ($urandom_range(0, 3) == 0) req_data = {$urandom, $urandom};
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
